// File: rtl/master_in_port.sv
// rtl/master_in_port.sv - serial-bus master receive port with framing check and valid/ready holding register
module master_in_port #(
  parameter int DATA_WIDTH = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic                  s_tx_done,
  input  logic                  rx_data,
  input  logic                  data_ready,
  output logic                  m_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  rx_done,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt, shifted, data_out_nxt;
  logic                  m_ready_nxt, data_valid_nxt, rx_done_nxt, frame_err_nxt;

  // First received bit ends up in bit 0 (LSB first) or in the MSB.
  assign shifted = LSB_FIRST ? {rx_data, shift_q[DATA_WIDTH-1:1]}
                             : {shift_q[DATA_WIDTH-2:0], rx_data};

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    shift_nxt      = shift_q;
    data_out_nxt   = data_out;
    data_valid_nxt = data_valid;
    rx_done_nxt    = 1'b0;
    frame_err_nxt  = 1'b0;

    if (data_valid && data_ready) data_valid_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (s_valid && m_ready) begin
          state_nxt = RECV;
          cnt_nxt   = '0;
          shift_nxt = '0;
        end
      end
      RECV: begin
        cnt_nxt   = cnt + 1'b1;
        shift_nxt = shifted;
        if (cnt == LAST_BIT) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          if (s_tx_done) begin
            data_out_nxt   = shifted;
            data_valid_nxt = 1'b1;
            rx_done_nxt    = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else if (s_tx_done) begin
          // Early end-of-frame: drop the partial word.
          state_nxt     = IDLE;
          cnt_nxt       = '0;
          frame_err_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Holding off m_ready while a word is pending makes overrun impossible.
    m_ready_nxt = (state_nxt == IDLE) && !data_valid_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      m_ready    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      shift_q    <= shift_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      rx_done    <= rx_done_nxt;
      frame_err  <= frame_err_nxt;
      m_ready    <= m_ready_nxt;
    end
  end

endmodule

// File: tb/tb_master_in_port.sv
// tb/tb_master_in_port.sv - directed plus randomized bench for master_in_port, LSB- and MSB-first instances
module tb_master_in_port;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_valid = 1'b0;
  logic s_tx_done = 1'b0;
  logic rx_data = 1'b0;
  logic data_ready = 1'b0;

  logic         m_ready_l, data_valid_l, rx_done_l, frame_err_l;
  logic [W-1:0] data_out_l;
  logic         m_ready_m, data_valid_m, rx_done_m, frame_err_m;
  logic [W-1:0] data_out_m;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each instance should be holding.
  logic [W-1:0] exp_l = '0;
  logic [W-1:0] exp_m = '0;
  logic         exp_valid = 1'b0;

  master_in_port #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_tx_done(s_tx_done),
    .rx_data(rx_data), .data_ready(data_ready), .m_ready(m_ready_l),
    .data_out(data_out_l), .data_valid(data_valid_l), .rx_done(rx_done_l),
    .frame_err(frame_err_l)
  );

  master_in_port #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_tx_done(s_tx_done),
    .rx_data(rx_data), .data_ready(data_ready), .m_ready(m_ready_m),
    .data_out(data_out_m), .data_valid(data_valid_m), .rx_done(rx_done_m),
    .frame_err(frame_err_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic mr, input logic rd, input logic fe);
    chk({tag, ".m_ready_l"}, 32'(m_ready_l), 32'(mr));
    chk({tag, ".m_ready_m"}, 32'(m_ready_m), 32'(mr));
    chk({tag, ".valid_l"}, 32'(data_valid_l), 32'(exp_valid));
    chk({tag, ".valid_m"}, 32'(data_valid_m), 32'(exp_valid));
    chk({tag, ".rx_done_l"}, 32'(rx_done_l), 32'(rd));
    chk({tag, ".rx_done_m"}, 32'(rx_done_m), 32'(rd));
    chk({tag, ".frame_err_l"}, 32'(frame_err_l), 32'(fe));
    chk({tag, ".frame_err_m"}, 32'(frame_err_m), 32'(fe));
    chk({tag, ".data_out_l"}, 32'(data_out_l), 32'(exp_l));
    chk({tag, ".data_out_m"}, 32'(data_out_m), 32'(exp_m));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends serial bits bits[0], bits[1], ... ; done_pos is the bit carrying s_tx_done (-1: none);
  // abort_at >= 0 pulls reset just after that bit's edge.
  task automatic send_frame(input logic [W-1:0] bits, input int done_pos, input bit hold_valid,
                            input int abort_at);
    int n = 0;
    while (!m_ready_l && n < 50) begin
      tick();
      n++;
    end
    chk("m_ready_before_frame", 32'(m_ready_l), 32'd1);
    if (!m_ready_l) return;
    s_valid = 1'b1;
    tick();
    chk_all("handshake", 1'b0, 1'b0, 1'b0);
    if (!hold_valid) s_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      rx_data   = bits[i];
      s_tx_done = (i == done_pos);
      tick();
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1;
        exp_l = '0;
        exp_m = '0;
        exp_valid = 1'b0;
        chk_all("async_reset", 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        s_valid = 1'b0;
        s_tx_done = 1'b0;
        tick();
        chk_all("after_reset_release", 1'b1, 1'b0, 1'b0);
        return;
      end
      if (i == done_pos && i < W - 1) begin
        s_tx_done = 1'b0;
        s_valid = 1'b0;
        chk_all("early_done", 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("early_done_after", 1'b1, 1'b0, 1'b0);
        return;
      end
      if (i < W - 1) chk_all("mid_frame", 1'b0, 1'b0, 1'b0);
    end
    s_tx_done = 1'b0;
    s_valid = 1'b0;
    if (done_pos == W - 1) begin
      exp_valid = 1'b1;
      exp_l = '0;
      exp_m = '0;
      for (int i = 0; i < W; i++) begin
        exp_l = exp_l | (W'(bits[i]) << i);
        exp_m = exp_m | (W'(bits[i]) << (W - 1 - i));
      end
      chk_all("frame_good", 1'b0, 1'b1, 1'b0);
    end else begin
      chk_all("missing_done", 1'b1, 1'b0, 1'b1);
      tick();
      chk_all("missing_done_after", 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    exp_valid = 1'b0;
    chk_all("consume", 1'b1, 1'b0, 1'b0);
    data_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    int r, dp;

    // 1: reset, then A5 with s_valid and data_ready already high
    s_valid = 1'b1;
    data_ready = 1'b1;
    tick();
    chk_all("in_reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_all("m_ready_rise", 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, W - 1, 1'b1, -1);
    chk("t1_data_out", 32'(data_out_l), 32'h0A5);
    data_ready = 1'b1;
    tick();
    exp_valid = 1'b0;
    chk_all("t1_consumed", 1'b1, 1'b0, 1'b0);
    data_ready = 1'b0;

    // 2: single leading 1 -> 01 LSB-first, 80 MSB-first
    send_frame(8'h01, W - 1, 1'b0, -1);
    chk("t2_msb_first", 32'(data_out_m), 32'h080);
    consume();

    // 3: pending word blocks new frames until consumed
    send_frame(8'h3C, W - 1, 1'b0, -1);
    s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("t3_hold", 1'b0, 1'b0, 1'b0);
    end
    s_valid = 1'b0;
    consume();
    send_frame(8'hC3, W - 1, 1'b0, -1);
    chk("t3_next_word", 32'(data_out_l), 32'h0C3);

    // 4: early s_tx_done on bit 4 while C3 still held (consume first so m_ready is up)
    consume();
    send_frame(8'hFF, 4, 1'b0, -1);
    chk("t4_data_kept", 32'(data_out_l), 32'h0C3);

    // 5: s_tx_done missing on last bit
    send_frame(8'h77, -1, 1'b0, -1);

    // 6: reset mid-frame, then a clean 5A
    send_frame(8'h99, W - 1, 1'b0, 3);
    send_frame(8'h5A, W - 1, 1'b0, -1);
    chk("t6_data_out", 32'(data_out_l), 32'h05A);
    consume();

    // randomized frames, including framing faults and consumer stalls
    for (int f = 0; f < 40; f++) begin
      w = W'($urandom);
      r = int'($urandom_range(0, 9));
      dp = (r < 7) ? W - 1 : (r == 7) ? -1 : int'($urandom_range(0, W - 2));
      send_frame(w, dp, 1'b0, -1);
      if (exp_valid) begin
        r = int'($urandom_range(0, 3));
        s_valid = $urandom_range(0, 1) == 1;
        for (int k = 0; k < r; k++) begin
          tick();
          chk_all("rand_stall", 1'b0, 1'b0, 1'b0);
        end
        s_valid = 1'b0;
        consume();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
